// File: rtl/spi_apb_pkg.sv
// ============================================================================
// Module   : spi_apb_pkg
// Brief    : Register word offsets, INTSTA bit indices and STATUS command bit
//            positions shared by the SPI master APB front-end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_apb_pkg;

  localparam logic [3:0] c_REG_STATUS = 4'h0;
  localparam logic [3:0] c_REG_CLKDIV = 4'h1;
  localparam logic [3:0] c_REG_SPICMD = 4'h2;
  localparam logic [3:0] c_REG_SPIADR = 4'h3;
  localparam logic [3:0] c_REG_SPILEN = 4'h4;
  localparam logic [3:0] c_REG_SPIDUM = 4'h5;
  localparam logic [3:0] c_REG_TXFIFO = 4'h6;
  localparam logic [3:0] c_REG_RXFIFO = 4'h8;
  localparam logic [3:0] c_REG_INTCFG = 4'h9;
  localparam logic [3:0] c_REG_INTSTA = 4'hA;

  localparam int c_INT_TXTH   = 0;
  localparam int c_INT_RXTH   = 1;
  localparam int c_INT_DONE   = 2;
  localparam int c_INT_TXOVF  = 3;
  localparam int c_INT_RXUNF  = 4;
  localparam int c_INT_CMDREJ = 5;

  localparam int c_CMD_RD     = 0;
  localparam int c_CMD_WR     = 1;
  localparam int c_CMD_QRD    = 2;
  localparam int c_CMD_QWR    = 3;
  localparam int c_CMD_SWRST  = 4;
  localparam int c_CMD_CS_LSB = 8;

endpackage

`default_nettype wire

// File: rtl/spi_apb_fifo.sv
// ============================================================================
// Module   : spi_apb_fifo
// Brief    : Synchronous FIFO with flush; push/pop silently ignored when
//            full/empty. DEPTH must be a power of two.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_apb_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int LOG_DEPTH = $clog2(DEPTH)
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata,
  output logic [LOG_DEPTH:0]   count
);

  localparam logic [LOG_DEPTH:0] c_DEPTH = (LOG_DEPTH+1)'(DEPTH);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [LOG_DEPTH-1:0] r_wptr;
  logic [LOG_DEPTH-1:0] r_rptr;
  logic [LOG_DEPTH:0]   r_count;
  logic                 w_push_ok;
  logic                 w_pop_ok;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign w_push_ok = push & ~flush & (r_count < c_DEPTH);
  assign w_pop_ok  = pop  & ~flush & (r_count != '0);
  assign rdata     = r_mem[r_rptr];
  assign count     = r_count;

  always_ff @(posedge HCLK) begin
    if (w_push_ok) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + LOG_DEPTH'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + LOG_DEPTH'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (LOG_DEPTH+1)'(1);
        2'b01:   r_count <= r_count - (LOG_DEPTH+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master_apb_fifo_if.sv
// ============================================================================
// Module   : spi_master_apb_fifo_if
// Brief    : APB register front-end for the SPI master with TX/RX FIFOs and
//            W1C interrupt status. Define SPI_APB_WAITSTATE_EN to stall APB on
//            full-TX writes / empty-RX reads instead of flagging errors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_apb_fifo_if
  import spi_apb_pkg::*;
#(
  parameter int BUFFER_DEPTH     = 8,
  parameter int APB_ADDR_WIDTH   = 12,
  parameter int NUM_CS           = 4,
  parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0]   PADDR,
  input  logic [31:0]                 PWDATA,
  input  logic                        PWRITE,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  output logic [31:0]                 PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic [15:0]                 spi_clk_div,
  output logic                        spi_clk_div_valid,
  output logic                        spi_cpol,
  output logic                        spi_cpha,
  output logic [31:0]                 spi_cmd,
  output logic [31:0]                 spi_addr,
  output logic [5:0]                  spi_cmd_len,
  output logic [5:0]                  spi_addr_len,
  output logic [15:0]                 spi_data_len,
  output logic [15:0]                 spi_dummy_rd,
  output logic [15:0]                 spi_dummy_wr,
  output logic [NUM_CS-1:0]           spi_csreg,
  output logic                        spi_rd,
  output logic                        spi_wr,
  output logic                        spi_qrd,
  output logic                        spi_qwr,
  output logic                        spi_swrst,
  input  logic                        spi_busy,
  output logic [31:0]                 spi_data_tx,
  output logic                        spi_data_tx_valid,
  input  logic                        spi_data_tx_ready,
  input  logic [31:0]                 spi_data_rx,
  input  logic                        spi_data_rx_valid,
  output logic                        spi_data_rx_ready,
  output logic [LOG_BUFFER_DEPTH:0]   spi_int_th_tx,
  output logic [LOG_BUFFER_DEPTH:0]   spi_int_th_rx,
  output logic                        spi_int_en,
  output logic                        spi_event
);

  localparam int                      L       = LOG_BUFFER_DEPTH;
  localparam logic [L:0]              c_DEPTH = (L+1)'(BUFFER_DEPTH);

  logic [3:0]  w_idx;
  logic        w_unmapped, w_bad, w_access, w_wr, w_rd;
  logic        w_is_tx, w_is_rx, w_is_status, w_flush;
  logic        w_tx_ovf, w_rx_unf;
  logic [L:0]  w_tx_count, w_rx_count;
  logic [31:0] w_rx_head, w_intcfg;
  logic [1:0]  w_live;
  logic [5:2]  w_set, w_clr;
  logic [5:2]  r_sticky;
  logic        r_busy_q;
  logic        w_unused;

  assign w_idx       = PADDR[5:2];
  assign w_unused    = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0]};
  assign w_is_tx     = (w_idx == c_REG_TXFIFO);
  assign w_is_rx     = (w_idx == c_REG_RXFIFO);
  assign w_is_status = (w_idx == c_REG_STATUS);

  always_comb begin
    w_unmapped = 1'b0;
    case (w_idx)
      4'h7, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: w_unmapped = 1'b1;
      default:                             w_unmapped = 1'b0;
    endcase
  end

`ifdef SPI_APB_WAITSTATE_EN
  assign PREADY   = ~(PSEL & PENABLE &
                      (( PWRITE & w_is_tx & (w_tx_count == c_DEPTH)) |
                       (~PWRITE & w_is_rx & (w_rx_count == '0))));
  assign w_tx_ovf = 1'b0;
  assign w_rx_unf = 1'b0;
`else
  assign PREADY   = 1'b1;
  assign w_tx_ovf = w_wr & w_is_tx & (w_tx_count == c_DEPTH);
  assign w_rx_unf = w_rd & w_is_rx & (w_rx_count == '0);
`endif

  assign w_access = PSEL & PENABLE & PREADY;
  assign w_bad    = w_unmapped | (PWRITE & w_is_rx);
  assign PSLVERR  = w_access & w_bad;
  assign w_wr     = w_access & ~w_bad &  PWRITE;
  assign w_rd     = w_access & ~w_bad & ~PWRITE;
  assign w_flush  = w_wr & w_is_status & PWDATA[c_CMD_SWRST];

  spi_apb_fifo #(.WIDTH(32), .DEPTH(BUFFER_DEPTH), .LOG_DEPTH(L)) u_tx_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .flush   (w_flush),
    .push    (w_wr & w_is_tx),
    .pop     (spi_data_tx_ready),
    .wdata   (PWDATA),
    .rdata   (spi_data_tx),
    .count   (w_tx_count)
  );

  spi_apb_fifo #(.WIDTH(32), .DEPTH(BUFFER_DEPTH), .LOG_DEPTH(L)) u_rx_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .flush   (w_flush),
    .push    (spi_data_rx_valid),
    .pop     (w_rd & w_is_rx),
    .wdata   (spi_data_rx),
    .rdata   (w_rx_head),
    .count   (w_rx_count)
  );

  assign spi_data_tx_valid = (w_tx_count != '0);
  assign spi_data_rx_ready = (w_rx_count < c_DEPTH);

  assign w_live[c_INT_TXTH] = (w_tx_count <= spi_int_th_tx);
  assign w_live[c_INT_RXTH] = (w_rx_count >= spi_int_th_rx) && (w_rx_count != '0);

  always_comb begin
    w_set               = '0;
    w_set[c_INT_DONE]   = r_busy_q & ~spi_busy;
    w_set[c_INT_TXOVF]  = w_tx_ovf;
    w_set[c_INT_RXUNF]  = w_rx_unf;
    w_set[c_INT_CMDREJ] = w_wr & w_is_status & spi_busy;
    w_clr               = (w_wr && w_idx == c_REG_INTSTA) ? PWDATA[5:2] : 4'b0;
  end

  always_comb begin
    w_intcfg               = '0;
    w_intcfg[L:0]          = spi_int_th_tx;
    w_intcfg[8 +: L+1]     = spi_int_th_rx;
    w_intcfg[31]           = spi_int_en;
    PRDATA                 = '0;
    case (w_idx)
      c_REG_STATUS: PRDATA = {8'(w_rx_count), 8'(w_tx_count), 15'b0, spi_busy};
      c_REG_CLKDIV: PRDATA = {14'b0, spi_cpol, spi_cpha, spi_clk_div};
      c_REG_SPICMD: PRDATA = spi_cmd;
      c_REG_SPIADR: PRDATA = spi_addr;
      c_REG_SPILEN: PRDATA = {spi_data_len, 2'b0, spi_addr_len, 2'b0, spi_cmd_len};
      c_REG_SPIDUM: PRDATA = {spi_dummy_wr, spi_dummy_rd};
      c_REG_RXFIFO: PRDATA = (w_rx_count != '0) ? w_rx_head : 32'b0;
      c_REG_INTCFG: PRDATA = w_intcfg;
      c_REG_INTSTA: PRDATA = {26'b0, r_sticky, w_live};
      default:      PRDATA = '0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      spi_clk_div       <= '0;
      spi_clk_div_valid <= 1'b0;
      spi_cpol          <= 1'b0;
      spi_cpha          <= 1'b0;
      spi_cmd           <= '0;
      spi_addr          <= '0;
      spi_cmd_len       <= '0;
      spi_addr_len      <= '0;
      spi_data_len      <= '0;
      spi_dummy_rd      <= '0;
      spi_dummy_wr      <= '0;
      spi_csreg         <= '0;
      spi_rd            <= 1'b0;
      spi_wr            <= 1'b0;
      spi_qrd           <= 1'b0;
      spi_qwr           <= 1'b0;
      spi_swrst         <= 1'b0;
      spi_int_th_tx     <= '0;
      spi_int_th_rx     <= '0;
      spi_int_en        <= 1'b0;
      spi_event         <= 1'b0;
      r_sticky          <= '0;
      r_busy_q          <= 1'b0;
    end else begin
      spi_clk_div_valid <= 1'b0;
      spi_rd            <= 1'b0;
      spi_wr            <= 1'b0;
      spi_qrd           <= 1'b0;
      spi_qwr           <= 1'b0;
      spi_swrst         <= 1'b0;
      r_busy_q          <= spi_busy;
      // Set wins over a same-cycle W1C.
      r_sticky          <= (r_sticky & ~w_clr) | w_set;
      spi_event         <= spi_int_en & (|{r_sticky, w_live});
      if (w_wr) begin
        case (w_idx)
          c_REG_STATUS: begin
            spi_swrst <= PWDATA[c_CMD_SWRST];
            if (!spi_busy) begin
              spi_rd    <= PWDATA[c_CMD_RD];
              spi_wr    <= PWDATA[c_CMD_WR];
              spi_qrd   <= PWDATA[c_CMD_QRD];
              spi_qwr   <= PWDATA[c_CMD_QWR];
              spi_csreg <= PWDATA[c_CMD_CS_LSB +: NUM_CS];
            end
          end
          c_REG_CLKDIV: begin
            spi_clk_div       <= PWDATA[15:0];
            spi_cpha          <= PWDATA[16];
            spi_cpol          <= PWDATA[17];
            spi_clk_div_valid <= 1'b1;
          end
          c_REG_SPICMD: spi_cmd <= PWDATA;
          c_REG_SPIADR: spi_addr <= PWDATA;
          c_REG_SPILEN: begin
            spi_cmd_len  <= PWDATA[5:0];
            spi_addr_len <= PWDATA[13:8];
            spi_data_len <= PWDATA[31:16];
          end
          c_REG_SPIDUM: begin
            spi_dummy_rd <= PWDATA[15:0];
            spi_dummy_wr <= PWDATA[31:16];
          end
          c_REG_INTCFG: begin
            spi_int_th_tx <= PWDATA[L:0];
            spi_int_th_rx <= PWDATA[8 +: L+1];
            spi_int_en    <= PWDATA[31];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_apb_fifo_if.sv
// ============================================================================
// Module   : tb_spi_master_apb_fifo_if
// Brief    : Directed self-checking bench for the SPI master APB front-end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_master_apb_fifo_if;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [15:0] spi_clk_div;
  logic        spi_clk_div_valid, spi_cpol, spi_cpha;
  logic [31:0] spi_cmd, spi_addr;
  logic [5:0]  spi_cmd_len, spi_addr_len;
  logic [15:0] spi_data_len, spi_dummy_rd, spi_dummy_wr;
  logic [3:0]  spi_csreg;
  logic        spi_rd, spi_wr, spi_qrd, spi_qwr, spi_swrst;
  logic        spi_busy = 1'b0;
  logic [31:0] spi_data_tx;
  logic        spi_data_tx_valid;
  logic        spi_data_tx_ready = 1'b0;
  logic [31:0] spi_data_rx = '0;
  logic        spi_data_rx_valid = 1'b0;
  logic        spi_data_rx_ready;
  logic [3:0]  spi_int_th_tx, spi_int_th_rx;
  logic        spi_int_en, spi_event;

  int n_checks = 0;
  int n_errors = 0;

  spi_master_apb_fifo_if #(.BUFFER_DEPTH(8), .APB_ADDR_WIDTH(12), .NUM_CS(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .spi_clk_div(spi_clk_div), .spi_clk_div_valid(spi_clk_div_valid),
    .spi_cpol(spi_cpol), .spi_cpha(spi_cpha),
    .spi_cmd(spi_cmd), .spi_addr(spi_addr),
    .spi_cmd_len(spi_cmd_len), .spi_addr_len(spi_addr_len),
    .spi_data_len(spi_data_len), .spi_dummy_rd(spi_dummy_rd), .spi_dummy_wr(spi_dummy_wr),
    .spi_csreg(spi_csreg),
    .spi_rd(spi_rd), .spi_wr(spi_wr), .spi_qrd(spi_qrd), .spi_qwr(spi_qwr), .spi_swrst(spi_swrst),
    .spi_busy(spi_busy),
    .spi_data_tx(spi_data_tx), .spi_data_tx_valid(spi_data_tx_valid),
    .spi_data_tx_ready(spi_data_tx_ready),
    .spi_data_rx(spi_data_rx), .spi_data_rx_valid(spi_data_rx_valid),
    .spi_data_rx_ready(spi_data_rx_ready),
    .spi_int_th_tx(spi_int_th_tx), .spi_int_th_rx(spi_int_th_rx),
    .spi_int_en(spi_int_en), .spi_event(spi_event)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    int n;
    @(negedge HCLK);
    PADDR = addr; PWDATA = wdata; PWRITE = wr; PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1;
    n = 0;
    while (!PREADY && n < 200) begin
      @(negedge HCLK); #1; n++;
    end
    if (!PREADY) check("pready_timeout", {31'b0, PREADY}, 32'd1);
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_wr(input logic [11:0] addr, input logic [31:0] wdata);
    logic [31:0] d; logic e;
    apb_xfer(1'b1, addr, wdata, d, e);
  endtask

  task automatic apb_rd(input logic [11:0] addr, output logic [31:0] rdata);
    logic e;
    apb_xfer(1'b0, addr, 32'b0, rdata, e);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;

    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    check("rst_pready",   {31'b0, PREADY}, 32'd1);
    check("rst_pslverr",  {31'b0, PSLVERR}, 32'd0);
    check("rst_event",    {31'b0, spi_event}, 32'd0);
    check("rst_clkdiv",   {16'b0, spi_clk_div}, 32'd0);
    check("rst_csreg",    {28'b0, spi_csreg}, 32'd0);
    check("rst_txvalid",  {31'b0, spi_data_tx_valid}, 32'd0);
    check("rst_rxready",  {31'b0, spi_data_rx_ready}, 32'd1);
    check("rst_status",   PRDATA, 32'd0);

    // Clock configuration
    apb_wr(12'h004, 32'h0003_0010);
    check("clkdiv",       {16'b0, spi_clk_div}, 32'h10);
    check("cpol",         {31'b0, spi_cpol}, 32'd1);
    check("cpha",         {31'b0, spi_cpha}, 32'd1);
    check("clkdiv_valid", {31'b0, spi_clk_div_valid}, 32'd1);
    @(posedge HCLK); #1;
    check("clkdiv_valid_drop", {31'b0, spi_clk_div_valid}, 32'd0);
    apb_rd(12'h004, d);
    check("clkdiv_rb", d, 32'h0003_0010);

    // Fill TX FIFO with the core stalled
    for (int i = 0; i < 8; i++) begin
      apb_wr(12'h018, 32'h100 + i);
      if (i == 0) begin
        check("tx_valid_latency", {31'b0, spi_data_tx_valid}, 32'd1);
        check("tx_head_first",    spi_data_tx, 32'h100);
      end
    end
`ifdef SPI_APB_WAITSTATE_EN
    fork
      apb_wr(12'h018, 32'h108);
      begin
        repeat (4) @(negedge HCLK);
        #2;
        check("tx_stall", {31'b0, PREADY}, 32'd0);
        spi_data_tx_ready = 1'b1;
        @(negedge HCLK);
        spi_data_tx_ready = 1'b0;
      end
    join
    apb_rd(12'h028, d);
    check("tx_ovf_never", (d >> 3) & 32'd1, 32'd0);
`else
    apb_wr(12'h018, 32'h108);
    apb_rd(12'h028, d);
    check("tx_ovf_set", (d >> 3) & 32'd1, 32'd1);
    apb_wr(12'h028, 32'h8);
    apb_rd(12'h028, d);
    check("tx_ovf_clr", (d >> 3) & 32'd1, 32'd0);
`endif
    apb_rd(12'h000, d);
    check("tx_count_full", (d >> 16) & 32'hFF, 32'd8);

    @(negedge HCLK);
    spi_data_tx_ready = 1'b1;
    repeat (5) @(posedge HCLK);
    @(negedge HCLK);
    spi_data_tx_ready = 1'b0;
    apb_rd(12'h000, d);
    check("tx_count_drain", (d >> 16) & 32'hFF, 32'd3);
`ifdef SPI_APB_WAITSTATE_EN
    check("tx_head_drain", spi_data_tx, 32'h106);
`else
    check("tx_head_drain", spi_data_tx, 32'h105);
`endif

    // RX round trip
    @(negedge HCLK);
    spi_data_rx_valid = 1'b1; spi_data_rx = 32'hA5A5_0001;
    @(negedge HCLK);
    spi_data_rx = 32'hA5A5_0002;
    @(negedge HCLK);
    spi_data_rx_valid = 1'b0;
    apb_rd(12'h000, d);
    check("rx_count2", (d >> 24) & 32'hFF, 32'd2);
    apb_rd(12'h020, d);
    check("rx_pop1", d, 32'hA5A5_0001);
    apb_rd(12'h020, d);
    check("rx_pop2", d, 32'hA5A5_0002);
    apb_rd(12'h000, d);
    check("rx_count0", (d >> 24) & 32'hFF, 32'd0);
`ifndef SPI_APB_WAITSTATE_EN
    apb_rd(12'h020, d);
    check("rx_empty_data", d, 32'd0);
    apb_rd(12'h028, d);
    check("rx_unf_set", (d >> 4) & 32'd1, 32'd1);
`endif

    // Commands, busy reject and done interrupt
    apb_wr(12'h000, 32'h202);
    check("cmd_wr_pulse", {31'b0, spi_wr}, 32'd1);
    check("cmd_csreg",    {28'b0, spi_csreg}, 32'd2);
    @(posedge HCLK); #1;
    check("cmd_wr_drop",  {31'b0, spi_wr}, 32'd0);
    @(negedge HCLK);
    spi_busy = 1'b1;
    apb_wr(12'h000, 32'h102);
    check("rej_no_wr",    {31'b0, spi_wr}, 32'd0);
    check("rej_csreg",    {28'b0, spi_csreg}, 32'd2);
    apb_rd(12'h028, d);
    check("rej_flag", (d >> 5) & 32'd1, 32'd1);
    apb_wr(12'h028, 32'h3C);
    apb_wr(12'h024, 32'h8000_0000);
    @(posedge HCLK); #1;
    check("event_idle", {31'b0, spi_event}, 32'd0);
    @(negedge HCLK);
    spi_busy = 1'b0;
    @(posedge HCLK); #1;
    check("event_busy_fall_p1", {31'b0, spi_event}, 32'd0);
    @(posedge HCLK); #1;
    check("event_busy_fall_p2", {31'b0, spi_event}, 32'd1);
    apb_rd(12'h028, d);
    check("intsta_done", d, 32'h4);

    // Error responses
    apb_xfer(1'b0, 12'h02C, 32'b0, d, e);
    check("err_2c_slverr", {31'b0, e}, 32'd1);
    check("err_2c_data",   d, 32'd0);
    apb_xfer(1'b0, 12'h01C, 32'b0, d, e);
    check("err_1c_slverr", {31'b0, e}, 32'd1);
    apb_xfer(1'b1, 12'h020, 32'hDEAD_BEEF, d, e);
    check("err_rxwr_slverr", {31'b0, e}, 32'd1);
    apb_rd(12'h000, d);
    check("err_rxwr_nochange", d, 32'h0003_0000);
    apb_xfer(1'b0, 12'h018, 32'b0, d, e);
    check("txfifo_rd_data",   d, 32'd0);
    check("txfifo_rd_slverr", {31'b0, e}, 32'd0);

    // Soft reset flushes the queued TX words
    apb_wr(12'h000, 32'h10);
    check("swrst_pulse",   {31'b0, spi_swrst}, 32'd1);
    check("swrst_txvalid", {31'b0, spi_data_tx_valid}, 32'd0);
    @(posedge HCLK); #1;
    check("swrst_drop",    {31'b0, spi_swrst}, 32'd0);
    apb_rd(12'h000, d);
    check("swrst_status",  d, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
